// File: rtl/apb_protocol_checker.sv
// Passive APB protocol checker and transfer observer: phase FSM, coded violation flags, transfer reports.
// Optional macro APB_CHK_ASSERT_EN adds one SVA assertion per violation code.
module apb_protocol_checker #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned NUM_SEL = 4,
  parameter int unsigned TIMEOUT = 16,
  parameter int unsigned CNT_W   = 8,
  localparam int unsigned SEL_W  = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1,
  localparam int unsigned WAIT_W = $clog2(TIMEOUT + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NUM_SEL-1:0] psel,
  input  logic              penable,
  input  logic              pwrite,
  input  logic              pready,
  input  logic              pslverr,
  input  logic [ADDR_W-1:0] paddr,
  input  logic [DATA_W-1:0] pwdata,
  input  logic [DATA_W-1:0] prdata,
  input  logic              clr,
  output logic              viol_valid,
  output logic [2:0]        viol_code,
  output logic [6:0]        viol_sticky,
  output logic [CNT_W-1:0]  viol_cnt,
  output logic              xfer_valid,
  output logic              xfer_wr,
  output logic              xfer_err,
  output logic [SEL_W-1:0]  xfer_sel,
  output logic [ADDR_W-1:0] xfer_addr,
  output logic [DATA_W-1:0] xfer_data,
  output logic [WAIT_W-1:0] xfer_waits
);

  typedef enum logic [1:0] {SYNC, IDLE, SETUP, ACCESS} state_e;

  state_e              state_q, state_d;
  logic [NUM_SEL-1:0]  psel_q, psel_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic                wr_q, wr_d;
  logic [DATA_W-1:0]   wdata_q, wdata_d;
  logic [WAIT_W-1:0]   wait_q, wait_d;
  logic                to_q, to_d;
  logic                done_q, done_d;

  logic                viol_valid_q, viol_valid_d;
  logic [2:0]          viol_code_q, viol_code_d;
  logic [6:0]          viol_sticky_q, viol_sticky_d;
  logic [CNT_W-1:0]    viol_cnt_q, viol_cnt_d;
  logic                xfer_valid_q, xfer_valid_d;
  logic                xfer_wr_q, xfer_wr_d;
  logic                xfer_err_q, xfer_err_d;
  logic [SEL_W-1:0]    xfer_sel_q, xfer_sel_d;
  logic [ADDR_W-1:0]   xfer_addr_q, xfer_addr_d;
  logic [DATA_W-1:0]   xfer_data_q, xfer_data_d;
  logic [WAIT_W-1:0]   xfer_waits_q, xfer_waits_d;

  logic                any_sel, multi_sel, mismatch;
  logic [WAIT_W-1:0]   wait_inc;
  logic [SEL_W-1:0]    sel_idx;
  logic [6:0]          codes;
  logic [2:0]          code_c;
  logic                capture, count_wait, complete;

  assign any_sel   = |psel;
  assign multi_sel = |(psel & (psel - NUM_SEL'(1)));
  assign mismatch  = (psel != psel_q) || (paddr != addr_q) || (pwrite != wr_q) ||
                     (pwrite && (pwdata != wdata_q));
  assign wait_inc  = (wait_q == WAIT_W'(TIMEOUT)) ? wait_q : wait_q + WAIT_W'(1);

  // Index of the lowest captured select line
  always_comb begin
    sel_idx = '0;
    for (int i = int'(NUM_SEL) - 1; i >= 0; i--) begin
      if (psel_q[i]) sel_idx = SEL_W'(i);
    end
  end

  always_comb begin
    state_d    = state_q;
    psel_d     = psel_q;
    addr_d     = addr_q;
    wr_d       = wr_q;
    wdata_d    = wdata_q;
    wait_d     = wait_q;
    to_d       = to_q;
    codes      = '0;
    capture    = 1'b0;
    count_wait = 1'b0;
    complete   = 1'b0;

    case (state_q)
      SYNC: if (!any_sel) state_d = IDLE;
      IDLE: begin
        if (penable) begin
          if (done_q) codes[4] = 1'b1;
          else        codes[0] = 1'b1;
        end else if (any_sel) begin
          capture = 1'b1;
          state_d = SETUP;
        end
      end
      SETUP: begin
        if (!any_sel) begin
          codes[3] = 1'b1;
          state_d  = IDLE;
        end else if (!penable) begin
          codes[6] = 1'b1;
          capture  = 1'b1;
        end else begin
          codes[2] = mismatch;
          if (pready) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            count_wait = 1'b1;
            state_d    = ACCESS;
          end
        end
      end
      ACCESS: begin
        if (!any_sel || !penable) begin
          codes[3] = 1'b1;
          state_d  = IDLE;
        end else begin
          codes[2] = mismatch;
          if (pready) begin
            complete = 1'b1;
            state_d  = IDLE;
          end else begin
            count_wait = 1'b1;
          end
        end
      end
      default: state_d = SYNC;
    endcase

    if (state_q != SYNC && multi_sel) codes[1] = 1'b1;

    if (capture) begin
      psel_d  = psel;
      addr_d  = paddr;
      wr_d    = pwrite;
      wdata_d = pwdata;
      wait_d  = '0;
      to_d    = 1'b0;
    end

    // Timeout fires only once per transfer, on the cycle the wait count reaches the limit
    if (count_wait) begin
      wait_d = wait_inc;
      if (wait_inc == WAIT_W'(TIMEOUT) && !to_q) begin
        codes[5] = 1'b1;
        to_d     = 1'b1;
      end
    end
  end

  always_comb begin
    code_c = 3'd0;
    for (int k = 6; k >= 0; k--) begin
      if (codes[k]) code_c = 3'(k + 1);
    end
  end

  always_comb begin
    done_d        = complete;
    viol_valid_d  = |codes;
    viol_code_d   = code_c;
    viol_sticky_d = clr ? codes : (viol_sticky_q | codes);
    if (clr)                                 viol_cnt_d = CNT_W'(|codes);
    else if ((|codes) && (viol_cnt_q != '1)) viol_cnt_d = viol_cnt_q + CNT_W'(1);
    else                                     viol_cnt_d = viol_cnt_q;
    xfer_valid_d = complete;
    xfer_wr_d    = xfer_wr_q;
    xfer_err_d   = xfer_err_q;
    xfer_sel_d   = xfer_sel_q;
    xfer_addr_d  = xfer_addr_q;
    xfer_data_d  = xfer_data_q;
    xfer_waits_d = xfer_waits_q;
    if (complete) begin
      xfer_wr_d    = wr_q;
      xfer_err_d   = pslverr;
      xfer_sel_d   = sel_idx;
      xfer_addr_d  = addr_q;
      xfer_data_d  = wr_q ? wdata_q : prdata;
      xfer_waits_d = wait_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= SYNC;
      psel_q        <= '0;
      addr_q        <= '0;
      wr_q          <= 1'b0;
      wdata_q       <= '0;
      wait_q        <= '0;
      to_q          <= 1'b0;
      done_q        <= 1'b0;
      viol_valid_q  <= 1'b0;
      viol_code_q   <= '0;
      viol_sticky_q <= '0;
      viol_cnt_q    <= '0;
      xfer_valid_q  <= 1'b0;
      xfer_wr_q     <= 1'b0;
      xfer_err_q    <= 1'b0;
      xfer_sel_q    <= '0;
      xfer_addr_q   <= '0;
      xfer_data_q   <= '0;
      xfer_waits_q  <= '0;
    end else begin
      state_q       <= state_d;
      psel_q        <= psel_d;
      addr_q        <= addr_d;
      wr_q          <= wr_d;
      wdata_q       <= wdata_d;
      wait_q        <= wait_d;
      to_q          <= to_d;
      done_q        <= done_d;
      viol_valid_q  <= viol_valid_d;
      viol_code_q   <= viol_code_d;
      viol_sticky_q <= viol_sticky_d;
      viol_cnt_q    <= viol_cnt_d;
      xfer_valid_q  <= xfer_valid_d;
      xfer_wr_q     <= xfer_wr_d;
      xfer_err_q    <= xfer_err_d;
      xfer_sel_q    <= xfer_sel_d;
      xfer_addr_q   <= xfer_addr_d;
      xfer_data_q   <= xfer_data_d;
      xfer_waits_q  <= xfer_waits_d;
    end
  end

  assign viol_valid  = viol_valid_q;
  assign viol_code   = viol_code_q;
  assign viol_sticky = viol_sticky_q;
  assign viol_cnt    = viol_cnt_q;
  assign xfer_valid  = xfer_valid_q;
  assign xfer_wr     = xfer_wr_q;
  assign xfer_err    = xfer_err_q;
  assign xfer_sel    = xfer_sel_q;
  assign xfer_addr   = xfer_addr_q;
  assign xfer_data   = xfer_data_q;
  assign xfer_waits  = xfer_waits_q;

`ifdef APB_CHK_ASSERT_EN
  a_penable_no_setup: assert property (@(posedge clk) disable iff (!rst_n) !(viol_valid && viol_code == 3'd1))
    else $error("APB PENABLE_WITHOUT_SETUP paddr=%h", paddr);
  a_multi_psel: assert property (@(posedge clk) disable iff (!rst_n) !(viol_valid && viol_code == 3'd2))
    else $error("APB MULTI_HOT_PSEL paddr=%h", paddr);
  a_unstable: assert property (@(posedge clk) disable iff (!rst_n) !(viol_valid && viol_code == 3'd3))
    else $error("APB SIGNAL_UNSTABLE paddr=%h", paddr);
  a_abandoned: assert property (@(posedge clk) disable iff (!rst_n) !(viol_valid && viol_code == 3'd4))
    else $error("APB TRANSFER_ABANDONED paddr=%h", paddr);
  a_penable_held: assert property (@(posedge clk) disable iff (!rst_n) !(viol_valid && viol_code == 3'd5))
    else $error("APB PENABLE_HELD paddr=%h", paddr);
  a_timeout: assert property (@(posedge clk) disable iff (!rst_n) !(viol_valid && viol_code == 3'd6))
    else $error("APB TIMEOUT paddr=%h", paddr);
  a_long_setup: assert property (@(posedge clk) disable iff (!rst_n) !(viol_valid && viol_code == 3'd7))
    else $error("APB LONG_SETUP paddr=%h", paddr);
`endif

endmodule

// File: tb/tb_apb_protocol_checker.sv
// Scoreboard bench for apb_protocol_checker: expected transfers/violations queued at stimulus, popped at output.
module tb_apb_protocol_checker;
  localparam int unsigned ADDR_W = 32, DATA_W = 32, NUM_SEL = 4, TIMEOUT = 4, CNT_W = 4;

  typedef struct packed {
    logic        wr;
    logic        err;
    logic [1:0]  sel;
    logic [31:0] addr;
    logic [31:0] data;
    logic [2:0]  waits;
  } xfer_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [3:0] psel = '0;
  logic penable = 0, pwrite = 0, pready = 0, pslverr = 0, clr = 0;
  logic [31:0] paddr = '0, pwdata = '0, prdata = '0;
  logic viol_valid, xfer_valid, xfer_wr, xfer_err;
  logic [2:0] viol_code, xfer_waits;
  logic [6:0] viol_sticky;
  logic [3:0] viol_cnt;
  logic [1:0] xfer_sel;
  logic [31:0] xfer_addr, xfer_data;

  int checks = 0, errors = 0;
  xfer_t xq[$];
  logic [2:0] vq[$];
  xfer_t exp_x, got_x;
  logic [2:0] exp_v;

  apb_protocol_checker #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NUM_SEL(NUM_SEL),
                         .TIMEOUT(TIMEOUT), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .pready(pready), .pslverr(pslverr), .paddr(paddr), .pwdata(pwdata), .prdata(prdata),
    .clr(clr), .viol_valid(viol_valid), .viol_code(viol_code), .viol_sticky(viol_sticky),
    .viol_cnt(viol_cnt), .xfer_valid(xfer_valid), .xfer_wr(xfer_wr), .xfer_err(xfer_err),
    .xfer_sel(xfer_sel), .xfer_addr(xfer_addr), .xfer_data(xfer_data), .xfer_waits(xfer_waits));

  always #5 clk = ~clk;

  // Output monitor: every pulse must match the head of its expectation queue
  always @(negedge clk) begin
    if (rst_n) begin
      if (viol_valid) begin
        checks = checks + 1;
        if (vq.size() == 0) begin
          errors = errors + 1;
          $display("FAIL viol_unexpected got code=%0d required none", viol_code);
        end else begin
          exp_v = vq.pop_front();
          if (viol_code !== exp_v) begin
            errors = errors + 1;
            $display("FAIL viol_code got %0d required %0d", viol_code, exp_v);
          end
        end
      end
      if (xfer_valid) begin
        checks = checks + 1;
        got_x = '{wr: xfer_wr, err: xfer_err, sel: xfer_sel, addr: xfer_addr, data: xfer_data, waits: xfer_waits};
        if (xq.size() == 0) begin
          errors = errors + 1;
          $display("FAIL xfer_unexpected got %h required none", got_x);
        end else begin
          exp_x = xq.pop_front();
          if (got_x !== exp_x) begin
            errors = errors + 1;
            $display("FAIL xfer_report got %h required %h", got_x, exp_x);
          end
        end
      end
    end
  end

  function automatic xfer_t mk(input logic wr, input logic err, input logic [1:0] sel,
                               input logic [31:0] a, input logic [31:0] d, input logic [2:0] w);
    return '{wr: wr, err: err, sel: sel, addr: a, data: d, waits: w};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus(input logic [3:0] s, input logic en, input logic wr, input logic rdy,
                     input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rd, input logic err);
    psel = s; penable = en; pwrite = wr; pready = rdy;
    paddr = a; pwdata = wd; prdata = rd; pslverr = err;
    tick();
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) bus(4'b0, 1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 32'h0, 1'b0);
  endtask

  task automatic drain_and_clear(input string name);
    idle(2);
    checks = checks + 1;
    if (vq.size() != 0 || xq.size() != 0) begin
      errors = errors + 1;
      $display("FAIL %s_pending got viol=%0d xfer=%0d outstanding required 0", name, vq.size(), xq.size());
      vq.delete(); xq.delete();
    end
    clr = 1'b1; idle(1); clr = 1'b0;
    checks = checks + 1;
    if (viol_sticky !== 7'h0 || viol_cnt !== 4'h0) begin
      errors = errors + 1;
      $display("FAIL %s_clr got sticky=%h cnt=%0d required 0/0", name, viol_sticky, viol_cnt);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle(3);
    checks = checks + 1;
    if ({viol_valid, viol_code, viol_sticky, viol_cnt} !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_viol got %b required 0", {viol_valid, viol_code, viol_sticky, viol_cnt});
    end
    checks = checks + 1;
    if ({xfer_valid, xfer_wr, xfer_err, xfer_sel, xfer_addr, xfer_data, xfer_waits} !== '0) begin
      errors = errors + 1;
      $display("FAIL reset_xfer got %h required 0", {xfer_valid, xfer_wr, xfer_err, xfer_sel, xfer_addr, xfer_data, xfer_waits});
    end
    rst_n = 1'b1;
    idle(2);
  endtask

  task automatic test_write();
    bus(4'b0001, 0, 1, 0, 32'h10, 32'hA5A5_0001, 32'h0, 0);
    xq.push_back(mk(1, 0, 2'd0, 32'h10, 32'hA5A5_0001, 3'd0));
    bus(4'b0001, 1, 1, 1, 32'h10, 32'hA5A5_0001, 32'h0, 0);
    checks = checks + 1;
    if (xfer_valid !== 1'b1 || viol_cnt !== 4'd0) begin
      errors = errors + 1;
      $display("FAIL write_latency got valid=%b cnt=%0d required 1/0", xfer_valid, viol_cnt);
    end
    drain_and_clear("write");
  endtask

  task automatic test_read_waits();
    bus(4'b0010, 0, 0, 0, 32'h40, 32'h0, 32'h0, 0);
    for (int i = 0; i < 3; i++) bus(4'b0010, 1, 0, 0, 32'h40, 32'h0, 32'h0, 0);
    xq.push_back(mk(0, 1, 2'd1, 32'h40, 32'h1234, 3'd3));
    bus(4'b0010, 1, 0, 1, 32'h40, 32'h0, 32'h1234, 1);
    idle(1);
    checks = checks + 1;
    if (viol_cnt !== 4'd0) begin
      errors = errors + 1;
      $display("FAIL read_cnt got %0d required 0", viol_cnt);
    end
    drain_and_clear("read");
  endtask

  task automatic test_timeout();
    bus(4'b0100, 0, 1, 0, 32'h80, 32'hDEAD, 32'h0, 0);
    for (int i = 1; i <= 6; i++) begin
      if (i == 4) vq.push_back(3'd6);
      bus(4'b0100, 1, 1, 0, 32'h80, 32'hDEAD, 32'h0, 0);
    end
    xq.push_back(mk(1, 0, 2'd2, 32'h80, 32'hDEAD, 3'd4));
    bus(4'b0100, 1, 1, 1, 32'h80, 32'hDEAD, 32'h0, 0);
    idle(1);
    checks = checks + 1;
    if (viol_sticky !== 7'h20 || viol_cnt !== 4'd1) begin
      errors = errors + 1;
      $display("FAIL timeout_flags got sticky=%h cnt=%0d required 20/1", viol_sticky, viol_cnt);
    end
    drain_and_clear("timeout");
  endtask

  task automatic test_unstable();
    bus(4'b0001, 0, 0, 0, 32'h20, 32'h0, 32'h0, 0);
    vq.push_back(3'd2);
    xq.push_back(mk(0, 0, 2'd0, 32'h20, 32'h55, 3'd0));
    bus(4'b0011, 1, 0, 1, 32'h24, 32'h0, 32'h55, 0);
    idle(1);
    checks = checks + 1;
    if (viol_sticky !== 7'h06 || viol_cnt !== 4'd1) begin
      errors = errors + 1;
      $display("FAIL unstable_flags got sticky=%h cnt=%0d required 06/1", viol_sticky, viol_cnt);
    end
    drain_and_clear("unstable");
  endtask

  task automatic test_penable();
    vq.push_back(3'd1);
    bus(4'b0000, 1, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    idle(1);
    bus(4'b0001, 0, 1, 0, 32'h30, 32'h77, 32'h0, 0);
    xq.push_back(mk(1, 0, 2'd0, 32'h30, 32'h77, 3'd0));
    bus(4'b0001, 1, 1, 1, 32'h30, 32'h77, 32'h0, 0);
    vq.push_back(3'd5);
    bus(4'b0001, 1, 1, 1, 32'h30, 32'h77, 32'h0, 0);
    idle(1);
    checks = checks + 1;
    if (viol_sticky !== 7'h11 || viol_cnt !== 4'd2) begin
      errors = errors + 1;
      $display("FAIL penable_flags got sticky=%h cnt=%0d required 11/2", viol_sticky, viol_cnt);
    end
    drain_and_clear("penable");
  endtask

  task automatic test_clr_overlap();
    clr = 1'b1;
    vq.push_back(3'd1);
    bus(4'b0000, 1, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    clr = 1'b0;
    checks = checks + 1;
    if (viol_sticky !== 7'h01 || viol_cnt !== 4'd1) begin
      errors = errors + 1;
      $display("FAIL clr_overlap got sticky=%h cnt=%0d required 01/1", viol_sticky, viol_cnt);
    end
    drain_and_clear("clr_overlap");
  endtask

  task automatic test_saturate();
    for (int i = 0; i < 20; i++) begin
      vq.push_back(3'd1);
      bus(4'b0000, 1, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    end
    idle(1);
    checks = checks + 1;
    if (viol_cnt !== 4'hF || viol_sticky !== 7'h01) begin
      errors = errors + 1;
      $display("FAIL saturate got cnt=%0d sticky=%h required 15/01", viol_cnt, viol_sticky);
    end
    drain_and_clear("saturate");
  endtask

  task automatic test_setup_faults();
    bus(4'b1000, 0, 0, 0, 32'h50, 32'h0, 32'h0, 0);
    vq.push_back(3'd7);
    bus(4'b1000, 0, 0, 0, 32'h54, 32'h0, 32'h0, 0);
    xq.push_back(mk(0, 0, 2'd3, 32'h54, 32'h99, 3'd0));
    bus(4'b1000, 1, 0, 1, 32'h54, 32'h0, 32'h99, 0);
    idle(1);
    bus(4'b0001, 0, 0, 0, 32'h60, 32'h0, 32'h0, 0);
    vq.push_back(3'd4);
    idle(1);
    bus(4'b0001, 0, 0, 0, 32'h64, 32'h0, 32'h0, 0);
    bus(4'b0001, 1, 0, 0, 32'h64, 32'h0, 32'h0, 0);
    vq.push_back(3'd4);
    bus(4'b0001, 0, 0, 0, 32'h64, 32'h0, 32'h0, 0);
    idle(1);
    checks = checks + 1;
    if (viol_sticky !== 7'h48 || viol_cnt !== 4'd3) begin
      errors = errors + 1;
      $display("FAIL setup_faults got sticky=%h cnt=%0d required 48/3", viol_sticky, viol_cnt);
    end
    drain_and_clear("setup_faults");
  endtask

  task automatic test_back_to_back();
    bus(4'b0001, 0, 1, 0, 32'h100, 32'h1, 32'h0, 0);
    xq.push_back(mk(1, 0, 2'd0, 32'h100, 32'h1, 3'd0));
    bus(4'b0001, 1, 1, 1, 32'h100, 32'h1, 32'h0, 0);
    bus(4'b0010, 0, 0, 0, 32'h104, 32'h0, 32'h0, 0);
    xq.push_back(mk(0, 0, 2'd1, 32'h104, 32'hBEEF, 3'd0));
    bus(4'b0010, 1, 0, 1, 32'h104, 32'h0, 32'hBEEF, 0);
    idle(1);
    checks = checks + 1;
    if (viol_cnt !== 4'd0) begin
      errors = errors + 1;
      $display("FAIL back_to_back_cnt got %0d required 0", viol_cnt);
    end
    drain_and_clear("back_to_back");
  endtask

  task automatic test_sync();
    bus(4'b0000, 1, 0, 0, 32'h0, 32'h0, 32'h0, 0);
    checks = checks + 1;
    if (viol_valid !== 1'b1 || viol_cnt !== 4'd1) begin
      errors = errors + 1;
      $display("FAIL pre_reset_viol got valid=%b cnt=%0d required 1/1", viol_valid, viol_cnt);
    end
    rst_n = 1'b0;
    #1;
    checks = checks + 1;
    if (viol_valid !== 1'b0 || viol_cnt !== 4'd0 || viol_code !== 3'd0) begin
      errors = errors + 1;
      $display("FAIL async_reset got valid=%b cnt=%0d code=%0d required 0/0/0", viol_valid, viol_cnt, viol_code);
    end
    psel = 4'b0001; penable = 1'b1; paddr = 32'h70;
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) bus(4'b0001, 1, 0, 0, 32'h70, 32'h0, 32'h0, 0);
    idle(2);
    bus(4'b0100, 0, 1, 0, 32'h74, 32'hCAFE, 32'h0, 0);
    xq.push_back(mk(1, 0, 2'd2, 32'h74, 32'hCAFE, 3'd0));
    bus(4'b0100, 1, 1, 1, 32'h74, 32'hCAFE, 32'h0, 0);
    idle(1);
    checks = checks + 1;
    if (viol_cnt !== 4'd0 || viol_sticky !== 7'h0) begin
      errors = errors + 1;
      $display("FAIL sync_quiet got cnt=%0d sticky=%h required 0/0", viol_cnt, viol_sticky);
    end
    drain_and_clear("sync");
  endtask

  initial begin
    test_reset();
    test_write();
    test_read_waits();
    test_timeout();
    test_unstable();
    test_penable();
    test_clr_overlap();
    test_saturate();
    test_setup_faults();
    test_back_to_back();
    test_sync();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/apb_protocol_checker.md
# apb_protocol_checker

Synthesizable, parametrised APB protocol checker and transfer observer for the SNN register bus. It sits passively on an APB segment between the testbench/host bridge and the SNN slaves. It tracks every transfer through a phase state machine and flags protocol violations as coded pulses, sticky bits and a saturating count. It also reports each completed transfer, including wait-state and PSLVERR information, so the same checks run in simulation, emulation and on silicon debug.

## Interface
- ADDR_W, 32, address width
- DATA_W, 32, data width
- NUM_SEL, 4, number of PSEL lines (slaves) on the segment
- TIMEOUT, 16, maximum allowed wait states before timeout (≥1)
- CNT_W, 8, violation counter width
- clk  input  1  bus clock
- rst_n  input  1  asynchronous active-low reset
- psel  input  NUM_SEL  slave selects
- penable, pwrite, pready, pslverr  input  1  APB controls
- paddr  input  ADDR_W  address
- pwdata, prdata  input  DATA_W  write/read data
- clr  input  1  synchronous clear of sticky flags and counter
- viol_valid  output  1  one-cycle pulse, violation detected
- viol_code  output  3  code of highest-priority violation (lowest number)
- viol_sticky  output  7  bit k-1 set on any code-k violation, held until clr
- viol_cnt  output  CNT_W  saturating violation-event count
- xfer_valid  output  1  one-cycle pulse, transfer completed
- xfer_wr, xfer_err  output  1  direction / sampled pslverr of completed transfer
- xfer_sel  output  $clog2(NUM_SEL)  index of selected slave
- xfer_addr  output  ADDR_W; xfer_data  output  DATA_W (pwdata for write, prdata for read)
- xfer_waits  output  $clog2(TIMEOUT+1)  wait states of completed transfer, saturating at TIMEOUT

## Operation
- All inputs are sampled on posedge clk. The FSM state reflects the phase of the previous sampled cycle.
- States: SYNC, IDLE, SETUP, ACCESS.
- SYNC (reset state): no checking. Go to IDLE on the first cycle with psel all-zero. This avoids false flags when reset releases mid-transfer.
- IDLE:
  - penable=1: code 5 if the previous cycle completed a transfer, else code 1. Stay in IDLE.
  - Any psel with penable=0: capture sel/addr/write/wdata, go to SETUP.
- SETUP:
  - psel all-zero: code 4, go to IDLE.
  - penable=0: code 7 (setup longer than one cycle), recapture, stay in SETUP.
  - Otherwise enter the access phase. If the captured fields differ from the current sample, flag code 3.
  - pready=1: complete and go to IDLE. pready=0: go to ACCESS with wait=1.
- ACCESS:
  - psel all-zero or penable=0: code 4, go to IDLE.
  - Field mismatch: code 3.
  - pready=1: complete, go to IDLE.
  - Otherwise wait++ (saturating). When wait reaches TIMEOUT, flag code 6 once per transfer.
- Code 2 (multi-hot psel) is checked in every non-SYNC state, alongside the other codes.
- Codes: 1 PENABLE without setup, 2 multi-hot PSEL, 3 signal unstable, 4 transfer abandoned, 5 PENABLE held after completion, 6 timeout, 7 long setup.
- The counter increments by 1 per violating cycle, regardless of how many codes fire, and saturates at 2^CNT_W-1.
- clr together with a new violation: the new violation wins. Sticky holds only the new bits; the count becomes 1.

## Timing
- All outputs are registered. Reset value of every output is 0.
- viol_* and xfer_* update 1 cycle after the sampling edge.
- Zero-wait transfer (SETUP, then ACCESS with pready=1): xfer_valid on the cycle after the ACCESS edge, with xfer_waits=0.
- Back-to-back transfers are legal. A new SETUP in the cycle right after completion gives no violation.
- rst_n assertion is asynchronous: FSM returns to SYNC, and outputs and pulses clear immediately.

## Configuration
- APB_CHK_ASSERT_EN defined: adds SVA concurrent assertions, one per violation code. Each is disabled iff !rst_n and calls $error with the code name and paddr when viol_valid fires with that code.
- Undefined: flags, counter and transfer reporting only. The block is fully synthesizable with no simulation-only constructs.

## Test plan
- Reset, then write addr 0x10, data 0xA5A5_0001, psel=0001, pready=1 in ACCESS → xfer_valid=1, xfer_wr=1, xfer_addr=0x10, xfer_waits=0, viol_cnt=0.
- Read with 3 wait cycles, prdata=0x1234 and pslverr=1 at completion → xfer_data=0x1234, xfer_err=1, xfer_waits=3.
- TIMEOUT=4, pready held low for 6 cycles → viol_code=6 pulses exactly once, viol_sticky[5]=1, viol_cnt=1.
- paddr changes 0x20→0x24 between SETUP and ACCESS, together with psel=0011 → viol_code=2, sticky bits 1 and 2 set, viol_cnt=1.
- penable=1 from IDLE; next transfer keeps penable high after completion; then clr pulse → codes 1 then 5, viol_cnt=2, then all sticky bits and the counter read 0.
- rst_n released while psel=0001 and penable=1 are held → no violation until psel drops; the following clean transfer reports normally.
